// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding and block constants for the SIMON stream controller
package simon_pkg;
  localparam int   BLOCK_W       = 128;
  localparam int   WORDS_PER_BLK = 4;
  localparam logic MODE_CBC      = 1'b1;
  localparam logic MODE_ECB      = 1'b0;
  typedef enum logic [1:0] {COLLECT, START, WAIT, EMIT} state_t;
endpackage

// File: rtl/simon_word_shreg.sv
// simon_word_shreg: block register that loads in parallel or shifts one word in at the bottom
module simon_word_shreg
  import simon_pkg::*;
#(
  parameter int W   = 32,
  parameter int BLK = BLOCK_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_load,
  input  logic           i_shift,
  input  logic [BLK-1:0] i_blk,
  input  logic [W-1:0]   i_word,
  output logic [BLK-1:0] o_blk,
  output logic [1:0]     o_cnt
);
  logic [BLK-1:0] r_blk;
  logic [1:0]     r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_blk <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_blk <= i_blk;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_blk <= {r_blk[BLK-W-1:0], i_word};
      r_cnt <= r_cnt + 2'd1;
    end
  end
  assign o_blk = r_blk;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/simon_stream_ctrl.sv
// simon_stream_ctrl: packs stream words into blocks for the SIMON128/128 core, applies CBC,
// and serialises the result back onto a valid/ready word stream.
module simon_stream_ctrl
  import simon_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cfg_load,
  input  logic               i_cfg_encrypt,
  input  logic               i_cfg_cbc,
  input  logic [BLOCK_W-1:0] i_cfg_key,
  input  logic [BLOCK_W-1:0] i_cfg_iv,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [WORD_W-1:0]  i_s_data,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [WORD_W-1:0]  o_m_data,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_core_start,
  output logic               o_core_encrypt,
  output logic [BLOCK_W-1:0] o_core_pt,
  output logic [BLOCK_W-1:0] o_core_key,
  input  logic               i_core_valid,
  input  logic [BLOCK_W-1:0] i_core_ct
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state, w_next;
  logic               r_live, r_enc, r_cbc, r_err, r_core_enc;
  logic [TO_W-1:0]    r_to;
  logic [BLOCK_W-1:0] r_key, r_chain, r_core_pt, r_core_key;
  logic [BLOCK_W-1:0] w_in_blk, w_out_blk, w_in_next, w_out_val;
  logic [1:0]         w_in_cnt, w_out_cnt;
  logic               w_in_hs, w_out_hs, w_load, w_in_last, w_out_last;
  logic               w_capture, w_timeout, w_cbc_enc;

  // r_live keeps s_ready low until the first edge after reset so every output reads 0 in reset
  assign o_s_ready  = r_live & (r_state == COLLECT) & ~i_cfg_load;
  assign o_m_valid  = (r_state == EMIT);
  assign o_core_start = (r_state == START);
  assign o_busy     = (r_state != COLLECT) | (w_in_cnt != 2'd0);
  assign o_err      = r_err;
  assign o_m_data   = w_out_blk[BLOCK_W-1 -: WORD_W];
  assign o_core_pt  = r_core_pt;
  assign o_core_key = r_core_key;
  assign o_core_encrypt = r_core_enc;

  assign w_in_hs    = o_s_ready & i_s_valid;
  assign w_out_hs   = o_m_valid & i_m_ready;
  assign w_load     = i_cfg_load & (r_state == COLLECT);
  assign w_in_last  = w_in_hs & (w_in_cnt == 2'(WORDS_PER_BLK - 1));
  assign w_out_last = w_out_hs & (w_out_cnt == 2'(WORDS_PER_BLK - 1));
  assign w_capture  = (r_state == WAIT) & i_core_valid;
  assign w_timeout  = (r_state == WAIT) & ~i_core_valid & (r_to == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_cbc_enc  = (r_cbc == MODE_CBC) & r_enc;
  assign w_in_next  = {w_in_blk[BLOCK_W-WORD_W-1:0], i_s_data};
  assign w_out_val  = ((r_cbc == MODE_CBC) & ~r_enc) ? i_core_ct ^ r_chain : i_core_ct;

  simon_word_shreg #(.W(WORD_W), .BLK(BLOCK_W)) u_in (
    .clk(clk), .rst_n(rst_n), .i_clr(w_load), .i_load(1'b0), .i_shift(w_in_hs),
    .i_blk('0), .i_word(i_s_data), .o_blk(w_in_blk), .o_cnt(w_in_cnt)
  );

  simon_word_shreg #(.W(WORD_W), .BLK(BLOCK_W)) u_out (
    .clk(clk), .rst_n(rst_n), .i_clr(1'b0), .i_load(w_capture), .i_shift(w_out_hs),
    .i_blk(w_out_val), .i_word('0), .o_blk(w_out_blk), .o_cnt(w_out_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: w_next = w_in_last ? START : COLLECT;
      START:   w_next = WAIT;
      WAIT:    w_next = i_core_valid ? EMIT : (w_timeout ? COLLECT : WAIT);
      EMIT:    w_next = w_out_last ? COLLECT : EMIT;
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_key      <= '0;
      r_chain    <= '0;
      r_enc      <= 1'b1;
      r_cbc      <= MODE_ECB;
      r_err      <= 1'b0;
      r_to       <= '0;
      r_core_pt  <= '0;
      r_core_key <= '0;
      r_core_enc <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_load) begin
        r_key   <= i_cfg_key;
        r_enc   <= i_cfg_encrypt;
        r_cbc   <= i_cfg_cbc;
        r_chain <= i_cfg_iv;
        r_err   <= 1'b0;
      end
      // the core operands are taken from the incoming last word so they are valid during START
      if (w_in_last) begin
        r_core_pt  <= w_cbc_enc ? w_in_next ^ r_chain : w_in_next;
        r_core_key <= r_key;
        r_core_enc <= r_enc;
      end
      if (w_capture && r_cbc == MODE_CBC) r_chain <= r_enc ? i_core_ct : w_in_blk;
      if (w_timeout) r_err <= 1'b1;
      r_to <= ((r_state == WAIT) && !i_core_valid && !w_timeout) ? r_to + TO_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_simon_stream_ctrl.sv
// tb_simon_stream_ctrl: table-driven bench with a behavioural SIMON128/128 core stub and an output scoreboard
module tb_simon_stream_ctrl;
  localparam logic [127:0] K  = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT = 128'h63736564_20737265_6c6c6576_61727420;
  localparam logic [127:0] CT = 128'h49681b1e_1e54fe3f_65aa832a_f84e0bbc;
  localparam logic [127:0] P1 = 128'h01234567_89abcdef_fedcba98_76543210;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_load = 1'b0, cfg_encrypt = 1'b0, cfg_cbc = 1'b0;
  logic [127:0] cfg_key = '0, cfg_iv = '0;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1;
  logic [31:0] s_data = '0, m_data;
  logic busy, err, core_start, core_encrypt, core_valid;
  logic [127:0] core_pt, core_key, core_ct;

  int n_run = 0, n_fail = 0, cyc = 0, hs_cyc = 0, mv_rise = 0, start_cyc = 0, stall_n = 0, rdy_mode = 0;
  logic core_mute = 1'b0;
  logic [31:0] exp_q[$];
  logic [127:0] got_blk = '0;

  simon_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_load(cfg_load), .i_cfg_encrypt(cfg_encrypt), .i_cfg_cbc(cfg_cbc),
    .i_cfg_key(cfg_key), .i_cfg_iv(cfg_iv), .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_busy(busy), .o_err(err),
    .o_core_start(core_start), .o_core_encrypt(core_encrypt), .o_core_pt(core_pt), .o_core_key(core_key),
    .i_core_valid(core_valid), .i_core_ct(core_ct)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [63:0] fr(input logic [63:0] x);
    return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
  endfunction

  function automatic logic [127:0] simon(input logic [127:0] blk, input logic [127:0] key, input bit enc);
    logic [63:0] k [68];
    logic [63:0] x, y, t, z;
    z = 64'h7369f885192c0ef5;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 2; i < 68; i++)
      k[i] = 64'hffff_ffff_ffff_fffc ^ {63'd0, z[(i - 2) % 62]} ^ k[i-2] ^ rotl(k[i-1], 61) ^ rotl(k[i-1], 60);
    x = blk[127:64];
    y = blk[63:0];
    if (enc) for (int i = 0; i < 68; i++) begin t = x; x = y ^ fr(x) ^ k[i]; y = t; end
    else for (int i = 67; i >= 0; i--) begin t = y; y = x ^ fr(y) ^ k[i]; x = t; end
    return {x, y};
  endfunction

  // core stub: 70 cycles from the start pulse to a one-cycle valid
  logic [6:0] stub_cnt;
  logic [127:0] stub_ct;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin stub_cnt <= '0; stub_ct <= '0; end
    else if (core_start) begin stub_cnt <= 7'd70; stub_ct <= simon(core_pt, core_key, core_encrypt); end
    else if (stub_cnt != 0) stub_cnt <= stub_cnt - 7'd1;
  assign core_valid = (stub_cnt == 7'd1) && !core_mute;
  assign core_ct = stub_ct;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void bad(input string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: bounded wait expired", nm);
  endfunction

  always @(posedge clk) begin
    #1;
    m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  logic prev_stall = 1'b0, prev_mv = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_mv = 1'b0;
    end else begin
      if (prev_stall && m_valid) begin
        stall_n++;
        chk("m_data_hold", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) bad("unexpected_word");
        else chk("m_word", m_data, exp_q.pop_front());
        got_blk = {got_blk[95:0], m_data};
      end
      if (m_valid && !prev_mv) mv_rise = cyc;
      if (core_start) start_cyc = cyc;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_mv = m_valid;
    end
  end

  typedef struct {
    bit load;
    bit enc;
    bit cbc;
    logic [127:0] iv;
    logic [127:0] pt;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic load_cfg(input bit enc, input bit cbc, input logic [127:0] iv);
    cfg_encrypt = enc; cfg_cbc = cbc; cfg_iv = iv; cfg_key = K; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_data = w;
    s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        hs_cyc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0;
        return;
      end
    end
    bad("s_ready_wait");
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++) send_word(b[127 - 32*i -: 32]);
  endtask

  task automatic push_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[127 - 32*i -: 32]);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin @(posedge clk); #1; return; end
    end
    bad({nm, "_done"});
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_row(input vec_t v, input string nm);
    if (v.load) load_cfg(v.enc, v.cbc, v.iv);
    push_blk(v.exp);
    send_blk(v.pt);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] c0, c1;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {s_ready, m_valid, busy, err, core_start, core_encrypt, m_data}, '0);
    chk("rst_core_pt", core_pt, '0);
    chk("rst_core_key", core_key, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    c0 = simon(PT ^ 128'd1, K, 1'b1);
    c1 = simon(P1 ^ c0, K, 1'b1);
    vecs[0] = '{1'b1, 1'b1, 1'b0, 128'd0, PT, CT};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 128'd0, CT, PT};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 128'd0, PT, CT};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 128'd0, P1, simon(P1 ^ CT, K, 1'b1)};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 128'd1, PT, c0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 128'd1, P1, c1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 128'd1, c0, PT};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 128'd1, c1, P1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 128'd0, P1, simon(P1, K, 1'b1)};

    for (int i = 0; i < 9; i++) begin
      rdy_mode = i % 2;
      run_row(vecs[i], $sformatf("row%0d", i));
      if (i == 0) begin
        chk("start_lat", 128'(start_cyc - hs_cyc), 128'd1);
        chk("valid_lat", 128'(mv_rise - hs_cyc), 128'd72);
        chk("core_key", core_key, K);
        chk("core_enc", core_encrypt, 1);
      end
      if (i == 1) chk("core_dec", core_encrypt, 0);
      if (i == 5) begin
        n_run++;
        if (got_blk === simon(P1, K, 1'b1)) begin
          n_fail++;
          $display("FAIL cbc_vs_ecb: got %h which equals the ECB ciphertext", got_blk);
        end
      end
    end
    rdy_mode = 0;

    // backpressure: hold m_ready low for 10 cycles after the first output word
    load_cfg(1'b1, 1'b0, '0);
    push_blk(CT);
    send_blk(PT);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 3) begin seen = 1; break; end
    end
    if (!seen) bad("bp_first_word");
    @(posedge clk); #1;
    stall_n = 0;
    rdy_mode = 2;
    repeat (11) @(posedge clk);
    #1 rdy_mode = 0;
    wait_done("backpressure");
    chk("bp_stall_seen", 128'(stall_n >= 9), 1);

    // cfg_load mid-block wins over a simultaneous input word and discards the partial block
    send_word(P1[127:96]);
    send_word(P1[95:64]);
    @(negedge clk);
    chk("partial_busy", busy, 1);
    @(posedge clk); #1;
    cfg_encrypt = 1'b1; cfg_cbc = 1'b0; cfg_key = K; cfg_iv = '0;
    cfg_load = 1'b1; s_valid = 1'b1; s_data = 32'hdeadbeef;
    @(negedge clk);
    chk("load_wins_ready", s_ready, 0);
    @(posedge clk); #1;
    cfg_load = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("load_clears_cnt", busy, 0);
    @(posedge clk); #1;
    push_blk(CT);
    send_blk(PT);
    wait_done("after_abort");

    // timeout with a silent core
    core_mute = 1'b1;
    send_blk(PT);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) begin seen = 1; break; end
    end
    if (!seen) bad("timeout_err");
    else begin
      chk("timeout_lat", 128'(cyc - hs_cyc), 128'd257);
      chk("timeout_ready", s_ready, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_mvalid", m_valid, 0);
    end
    @(posedge clk); #1;
    core_mute = 1'b0;
    load_cfg(1'b1, 1'b0, '0);
    @(negedge clk);
    chk("err_cleared", err, 0);
    @(posedge clk); #1;

    // reset in WAIT, then a normal block
    send_blk(PT);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_ctl", {s_ready, m_valid, busy, err, core_start, core_encrypt, m_data}, '0);
    chk("midrst_core_pt", core_pt, '0);
    chk("midrst_core_key", core_key, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 1);
    @(posedge clk); #1;
    run_row(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
